// File: rtl/scu_dsp_dma_seq.sv
// SCU DSP data-RAM bank set with per-bank CT pointers and a single D0-bus DMA sequencer.
// Optional abort input: define SCU_DSP_DMA_ABORT_EN.
module scu_dsp_dma_seq #(
  parameter int NBANK = 4,
  parameter int AW    = 6,
  parameter int DW    = 32,
  parameter int CW    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ce_i,
  input  logic                       ce_r_i,
  input  logic [NBANK-1:0]           core_cti_i,
  input  logic [NBANK-1:0]           core_ctw_i,
  input  logic [AW-1:0]              core_ct_d_i,
  input  logic [NBANK-1:0]           core_we_i,
  input  logic [DW-1:0]              core_d_i,
  output logic [NBANK*DW-1:0]        ram_q_o,
  output logic [NBANK*AW-1:0]        ct_o,
  input  logic                       st_i,
  input  logic                       dir_i,
  input  logic [$clog2(NBANK)-1:0]   bank_i,
  input  logic [CW-1:0]              cnt_i,
  input  logic                       hold_i,
  output logic                       busy_o,
  output logic                       dma_req_o,
  input  logic                       dma_ack_i,
  input  logic [DW-1:0]              dma_di_i,
  output logic [DW-1:0]              dma_do_o,
  output logic                       dma_we_o,
  output logic                       dma_last_o,
  input  logic                       dma_end_i,
`ifdef SCU_DSP_DMA_ABORT_EN
  input  logic                       abort_i,
`endif
  output logic                       done_o
);
  localparam int BW    = $clog2(NBANK);
  localparam int DEPTH = 2**AW;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_FIN} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d, dir_q, dir_d, hold_q, hold_d;
  logic            pend_q, pend_d, done_q, done_d;
  logic [BW-1:0]   bank_q, bank_d;
  logic [CW:0]     rem_q, rem_d;
  logic [AW-1:0]   ct_q [NBANK];
  logic [AW-1:0]   ct_d [NBANK];
  logic [DW-1:0]   mem_q [NBANK][DEPTH];
  logic [DW-1:0]   rd_q [NBANK];
  logic [DW-1:0]   wdat [NBANK];
  logic [NBANK-1:0] own, wen;
  logic            busy, step, abort_hit;

  assign busy = (state_q != S_IDLE);
`ifdef SCU_DSP_DMA_ABORT_EN
  assign abort_hit = ce_r_i & abort_i & ((state_q == S_XFER) | (state_q == S_DRAIN));
`else
  assign abort_hit = 1'b0;
`endif
  // one bus word retires on a qualified ack while the request is up
  assign step = (state_q == S_XFER) & req_q & ce_r_i & dma_ack_i & ~abort_hit;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    bank_d  = bank_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    done_d  = ce_i ? 1'b0 : done_q;
    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (ce_i & st_i) begin
          dir_d   = dir_i;
          bank_d  = bank_i;
          hold_d  = hold_i;
          rem_d   = (cnt_i == '0) ? {1'b1, {CW{1'b0}}} : {1'b0, cnt_i};
          req_d   = 1'b1;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (dma_end_i) pend_d = 1'b1;
        if (step) begin
          rem_d = rem_q - (CW+1)'(1);
          if (rem_q == (CW+1)'(1)) begin
            req_d   = 1'b0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: if (dma_end_i | pend_q) state_d = S_FIN;
      S_FIN: begin
        if (ce_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      req_d   = 1'b0;
      rem_d   = '0;
      state_d = S_FIN;
    end
  end

  always_comb begin
    for (int b = 0; b < NBANK; b++) own[b] = busy & (bank_q == BW'(b));
  end

  // the active bank belongs to the DMA; a core CTI still merges into a single +1
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      wen[b]  = 1'b0;
      wdat[b] = core_d_i;
      if (step & ~dir_q & own[b]) begin
        wen[b]  = 1'b1;
        wdat[b] = dma_di_i;
      end else if (ce_i & core_we_i[b] & ~own[b]) begin
        wen[b]  = 1'b1;
      end
      ct_d[b] = ct_q[b];
      if (ce_i & core_ctw_i[b] & ~own[b])
        ct_d[b] = core_ct_d_i;
      else if ((ce_i & core_cti_i[b]) | (step & own[b] & ~hold_q))
        ct_d[b] = ct_q[b] + AW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      bank_q  <= '0;
      hold_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int b = 0; b < NBANK; b++) ct_q[b] <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      bank_q  <= bank_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      for (int b = 0; b < NBANK; b++) ct_q[b] <= ct_d[b];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBANK; b++) begin
      if (wen[b]) mem_q[b][ct_q[b]] <= wdat[b];
      rd_q[b] <= mem_q[b][ct_q[b]];
    end
  end

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      ram_q_o[b*DW +: DW] = rd_q[b];
      ct_o[b*AW +: AW]    = ct_q[b];
    end
  end

  assign busy_o     = busy;
  assign dma_req_o  = req_q;
  assign dma_do_o   = rd_q[bank_q];
  assign dma_we_o   = dir_q;
  assign dma_last_o = busy & (rem_q == (CW+1)'(1));
  assign done_o     = done_q;
endmodule

// File: tb/tb_scu_dsp_dma_seq.sv
// Randomized bench for scu_dsp_dma_seq against a transaction-level model of banks, CTs and transfers.
module tb_scu_dsp_dma_seq;
  localparam int NBANK = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int CW    = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ce_i = 1'b1, ce_r_i = 1'b0;
  logic [3:0]  core_cti_i = '0, core_ctw_i = '0, core_we_i = '0;
  logic [5:0]  core_ct_d_i = '0;
  logic [31:0] core_d_i = '0;
  logic [127:0] ram_q_o;
  logic [23:0] ct_o;
  logic        st_i = 1'b0, dir_i = 1'b0, hold_i = 1'b0;
  logic [1:0]  bank_i = '0;
  logic [7:0]  cnt_i = '0;
  logic        busy_o, dma_req_o, dma_we_o, dma_last_o, done_o;
  logic        dma_ack_i = 1'b0, dma_end_i = 1'b0;
  logic [31:0] dma_di_i = '0, dma_do_o;
`ifdef SCU_DSP_DMA_ABORT_EN
  logic        abort_i = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem_m [NBANK][64];
  logic [5:0]  ct_m [NBANK];

  always #5 clk = ~clk;

  scu_dsp_dma_seq #(.NBANK(NBANK), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ce_i(ce_i), .ce_r_i(ce_r_i),
    .core_cti_i(core_cti_i), .core_ctw_i(core_ctw_i), .core_ct_d_i(core_ct_d_i),
    .core_we_i(core_we_i), .core_d_i(core_d_i), .ram_q_o(ram_q_o), .ct_o(ct_o),
    .st_i(st_i), .dir_i(dir_i), .bank_i(bank_i), .cnt_i(cnt_i), .hold_i(hold_i),
    .busy_o(busy_o), .dma_req_o(dma_req_o), .dma_ack_i(dma_ack_i), .dma_di_i(dma_di_i),
    .dma_do_o(dma_do_o), .dma_we_o(dma_we_o), .dma_last_o(dma_last_o),
    .dma_end_i(dma_end_i),
`ifdef SCU_DSP_DMA_ABORT_EN
    .abort_i(abort_i),
`endif
    .done_o(done_o));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ramq(input int b);
    return ram_q_o[b*DW +: DW];
  endfunction

  function automatic logic [5:0] ctv(input int b);
    return ct_o[b*AW +: AW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_ctw(input int b, input logic [5:0] v);
    core_ctw_i  = 4'(1 << b);
    core_ct_d_i = v;
    tick();
    core_ctw_i  = '0;
    ct_m[b]     = v;
  endtask

  task automatic read_chk(input int b, input logic [5:0] a);
    core_ctw(b, a);
    tick();
    check("ram_rd", 64'(ramq(b)), 64'(mem_m[b][a]));
  endtask

  task automatic check_all_ct();
    for (int b = 0; b < NBANK; b++) check("ct", 64'(ctv(b)), 64'(ct_m[b]));
  endtask

  task automatic wait_done();
    logic seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      if (done_o) seen = 1'b1;
      else tick();
    end
    check("done_seen", 64'(seen), 64'(1));
    if (seen) begin
      check("busy_after", 64'(busy_o), 64'(0));
      tick();
      check("done_pulse", 64'(done_o), 64'(0));
    end
  endtask

  // One whole transfer: word i targets CT0 + i unless HOLD; count 0 means 256 words.
  task automatic run_xfer(input logic dir, input int b, input int cnt, input logic hold,
                          input int contend_at, input int end_mode, input int rst_at,
                          input int abort_at);
    int n;
    logic [5:0] addr;
    n    = (cnt == 0) ? 256 : cnt;
    addr = ct_m[b];
    st_i = 1'b1; dir_i = dir; bank_i = 2'(b); cnt_i = 8'(cnt); hold_i = hold;
    tick();
    st_i = 1'b0;
    check("busy_start", 64'(busy_o), 64'(1));
    check("req_start", 64'(dma_req_o), 64'(1));
    check("dma_we", 64'(dma_we_o), 64'(dir));
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 2)) begin
        ce_r_i    = 1'($urandom_range(0, 1));
        dma_ack_i = ce_r_i ? 1'b0 : 1'($urandom_range(0, 1));
        tick();
      end
      dma_ack_i = 1'b0;
      if (i == rst_at) begin
        rst_ni = 1'b0;
        #1;
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_req", 64'(dma_req_o), 64'(0));
        for (int k = 0; k < NBANK; k++) ct_m[k] = '0;
        tick();
        check_all_ct();
        rst_ni = 1'b1;
        tick();
        return;
      end
      if (i == abort_at) begin
`ifdef SCU_DSP_DMA_ABORT_EN
        ce_r_i = 1'b1; abort_i = 1'b1;
        tick();
        abort_i = 1'b0; ce_r_i = 1'b0;
        check("abort_req", 64'(dma_req_o), 64'(0));
        wait_done();
        ct_m[b] = addr;
        check("ct_abort", 64'(ctv(b)), 64'(addr));
        return;
`endif
      end
      ce_r_i    = 1'b1;
      dma_ack_i = 1'b1;
      dma_di_i  = $urandom;
      check("busy_xfer", 64'(busy_o), 64'(1));
      check("req_xfer", 64'(dma_req_o), 64'(1));
      check("last", 64'(dma_last_o), 64'(i == n - 1));
      if (dir) check("dma_do", 64'(dma_do_o), 64'(mem_m[b][addr]));
      if (i == contend_at) begin
        core_cti_i = 4'(1 | (1 << b));
        core_we_i  = 4'(1 << b);
        core_d_i   = ~dma_di_i;
        st_i       = 1'b1;
        cnt_i      = 8'd1;
      end
      if (i == n - 1 && end_mode == 0) dma_end_i = 1'b1;
      tick();
      if (!dir) mem_m[b][addr] = dma_di_i;
      if (i == contend_at) ct_m[0] = ct_m[0] + 6'd1;
      if (!hold || i == contend_at) addr = addr + 6'd1;
      core_cti_i = '0; core_we_i = '0; st_i = 1'b0;
      dma_ack_i = 1'b0; dma_end_i = 1'b0; ce_r_i = 1'b0;
    end
    check("req_drop", 64'(dma_req_o), 64'(0));
    if (end_mode != 0) begin
      repeat (end_mode) tick();
      check("busy_drain", 64'(busy_o), 64'(1));
      dma_end_i = 1'b1;
      tick();
      dma_end_i = 1'b0;
    end
    wait_done();
    ct_m[b] = addr;
    check("ct_end", 64'(ctv(b)), 64'(addr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, required completion");
    $fatal(1);
  end

  initial begin
    for (int b = 0; b < NBANK; b++) ct_m[b] = '0;
    repeat (2) tick();
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_req", 64'(dma_req_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_last", 64'(dma_last_o), 64'(0));
    check("rst_we", 64'(dma_we_o), 64'(0));
    check_all_ct();
    rst_ni = 1'b1;
    tick();

    // preload every bank through the core port (write + increment together)
    for (int b = 0; b < NBANK; b++) begin
      for (int a = 0; a < 64; a++) begin
        core_we_i = 4'(1 << b); core_cti_i = 4'(1 << b); core_d_i = $urandom;
        tick();
        mem_m[b][ct_m[b]] = core_d_i;
        ct_m[b] = ct_m[b] + 6'd1;
      end
      core_we_i = '0; core_cti_i = '0;
    end
    check_all_ct();

    // core operations without CE do nothing
    ce_i = 1'b0; core_ctw_i = 4'b0100; core_ct_d_i = 6'h2A; core_we_i = 4'b0100;
    tick();
    ce_i = 1'b1; core_ctw_i = '0; core_we_i = '0;
    check("ce_gate_ct", 64'(ctv(2)), 64'(ct_m[2]));
    read_chk(2, 6'h00);

    core_ctw(1, 6'h10);
    run_xfer(1'b0, 1, 4, 1'b0, -1, 2, -1, -1);
    for (int a = 0; a < 4; a++) read_chk(1, 6'(16 + a));

    core_ctw(3, 6'd5);
    core_we_i = 4'b1000; core_d_i = 32'hDEADBEEF;
    tick();
    core_we_i = '0;
    mem_m[3][5] = 32'hDEADBEEF;
    tick();
    run_xfer(1'b1, 3, 3, 1'b1, -1, 1, -1, -1);

    core_ctw(0, 6'h3E);
    run_xfer(1'b0, 0, 0, 1'b0, -1, 0, -1, -1);
    read_chk(0, 6'h3E);
    read_chk(0, 6'h05);

    run_xfer(1'b0, 2, 6, 1'b0, 2, 3, -1, -1);
    check_all_ct();
    read_chk(2, ct_m[2] - 6'd4);

    core_ctw(1, 6'd3);
    run_xfer(1'b0, 1, 5, 1'b0, -1, 1, 2, -1);
    run_xfer(1'b0, 1, 3, 1'b0, -1, 0, -1, -1);
    read_chk(1, 6'd1);

`ifdef SCU_DSP_DMA_ABORT_EN
    core_ctw(2, 6'd9);
    run_xfer(1'b0, 2, 8, 1'b0, -1, 0, -1, 1);
`endif

    for (int r = 0; r < 30; r++) begin
      int b, cnt, cont;
      logic dir, hold;
      logic [5:0] ct0;
      b    = int'($urandom_range(0, 3));
      cnt  = int'($urandom_range(1, 10));
      dir  = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0);
      cont = (b != 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
      ct0  = 6'($urandom);
      core_ctw(b, ct0);
      run_xfer(dir, b, cnt, hold, cont, int'($urandom_range(0, 3)), -1, -1);
      check_all_ct();
      read_chk(b, ct0 + 6'($urandom_range(0, cnt - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
